// File: rtl/lcd_fill_rect.sv
// Rectangle-fill command generator for the ST7735 SPI path.
// Sends CASET/RASET/RAMWR followed by two RGB565 colour bytes per pixel, one byte per lcd_write handshake.
module lcd_fill_rect #(
    parameter int X_OFFSET = 2,
    parameter int Y_OFFSET = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        fill_flag,
    input  logic [8:0]  x_start,
    input  logic [8:0]  x_end,
    input  logic [8:0]  y_start,
    input  logic [8:0]  y_end,
    input  logic [15:0] color,
    input  logic        wr_done,
    output logic [8:0]  fill_data,
    output logic        en_write_fill,
    output logic        busy,
    output logic        fill_done
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SEND,
        WAIT,
        NEXT,
        DONE
    } state_t;

    // Byte indices 0..10 are the command header; index 11 means "in the pixel loop".
    localparam logic [3:0] PIX_IDX = 4'd11;

    localparam logic [8:0] CMD_CASET = 9'h02A;
    localparam logic [8:0] CMD_RASET = 9'h02B;
    localparam logic [8:0] CMD_RAMWR = 9'h02C;

    state_t      state;
    state_t      state_nxt;

    logic [8:0]  x_start_r;
    logic [8:0]  x_end_r;
    logic [8:0]  y_start_r;
    logic [8:0]  y_end_r;
    logic [15:0] color_r;

    logic [8:0]  col_cnt;
    logic [8:0]  row_cnt;
    logic [3:0]  byte_idx;
    logic        pix_half;

    logic [15:0] xs_addr;
    logic [15:0] xe_addr;
    logic [15:0] ys_addr;
    logic [15:0] ye_addr;
    logic        rect_valid;
    logic        last_pixel;
    logic [8:0]  cur_byte;

    // Panel addresses are 16 bits wide so an offset past column/row 511 is not lost.
    assign xs_addr = 16'(x_start_r) + 16'(X_OFFSET);
    assign xe_addr = 16'(x_end_r)   + 16'(X_OFFSET);
    assign ys_addr = 16'(y_start_r) + 16'(Y_OFFSET);
    assign ye_addr = 16'(y_end_r)   + 16'(Y_OFFSET);

    assign rect_valid = (x_end_r >= x_start_r) && (y_end_r >= y_start_r);
    assign last_pixel = (byte_idx == PIX_IDX) && pix_half &&
                        (col_cnt == x_end_r) && (row_cnt == y_end_r);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur_byte = {1'b1, pix_half ? color_r[7:0] : color_r[15:8]};
        case (byte_idx)
            4'd0:    cur_byte = CMD_CASET;
            4'd1:    cur_byte = {1'b1, xs_addr[15:8]};
            4'd2:    cur_byte = {1'b1, xs_addr[7:0]};
            4'd3:    cur_byte = {1'b1, xe_addr[15:8]};
            4'd4:    cur_byte = {1'b1, xe_addr[7:0]};
            4'd5:    cur_byte = CMD_RASET;
            4'd6:    cur_byte = {1'b1, ys_addr[15:8]};
            4'd7:    cur_byte = {1'b1, ys_addr[7:0]};
            4'd8:    cur_byte = {1'b1, ye_addr[15:8]};
            4'd9:    cur_byte = {1'b1, ye_addr[7:0]};
            4'd10:   cur_byte = CMD_RAMWR;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fill_flag) state_nxt = CHECK;
            CHECK:   state_nxt = rect_valid ? SEND : DONE;
            SEND:    state_nxt = WAIT;
            WAIT:    if (wr_done) state_nxt = NEXT;
            NEXT:    state_nxt = last_pixel ? DONE : SEND;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            x_start_r     <= '0;
            x_end_r       <= '0;
            y_start_r     <= '0;
            y_end_r       <= '0;
            color_r       <= '0;
            col_cnt       <= '0;
            row_cnt       <= '0;
            byte_idx      <= '0;
            pix_half      <= 1'b0;
            fill_data     <= 9'h000;
            en_write_fill <= 1'b0;
            busy          <= 1'b0;
            fill_done     <= 1'b0;
        end else begin
            en_write_fill <= 1'b0;
            fill_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_flag) begin
                        x_start_r <= x_start;
                        x_end_r   <= x_end;
                        y_start_r <= y_start;
                        y_end_r   <= y_end;
                        color_r   <= color;
                        col_cnt   <= x_start;
                        row_cnt   <= y_start;
                        byte_idx  <= '0;
                        pix_half  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    fill_data     <= cur_byte;
                    en_write_fill <= 1'b1;
                end
                NEXT: begin
                    if (byte_idx != PIX_IDX) begin
                        byte_idx <= byte_idx + 4'd1;
                    end else if (!pix_half) begin
                        pix_half <= 1'b1;
                    end else begin
                        pix_half <= 1'b0;
                        // Compare before incrementing so x_end = 511 never wraps the counter.
                        if (col_cnt == x_end_r) begin
                            col_cnt <= x_start_r;
                            row_cnt <= row_cnt + 9'd1;
                        end else begin
                            col_cnt <= col_cnt + 9'd1;
                        end
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    fill_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lcd_fill_rect.md
Name: lcd_fill_rect

Overview:
- Rectangle-fill command generator for the ST7735 SPI LCD path. It is a sibling source to the character renderer.
- On a start pulse it emits this byte stream, one byte per lcd_write handshake:
  - CASET (0x2A) plus 4 column bytes,
  - RASET (0x2B) plus 4 row bytes,
  - RAMWR (0x2C),
  - then 2 colour bytes per pixel.
- Output feeds the mux ahead of lcd_write and is used for screen clears and solid backgrounds on mode changes.

Parameters:
- X_OFFSET, 2, panel column offset added to both column addresses.
- Y_OFFSET, 1, panel row offset added to both row addresses.

Ports:
- sys_clk  input  1  system clock (PLL output)
- sys_rst_n  input  1  synchronous active-low reset
- fill_flag  input  1  start request, single-cycle pulse, sampled only in IDLE
- x_start  input  9  first column, inclusive
- x_end  input  9  last column, inclusive
- y_start  input  9  first row, inclusive
- y_end  input  9  last row, inclusive
- color  input  16  RGB565 fill colour
- wr_done  input  1  lcd_write byte-complete pulse
- fill_data  output  9  bit8 = DC level (0 command, 1 data), bits7:0 = byte
- en_write_fill  output  1  one-cycle write strobe to lcd_write
- busy  output  1  high from acceptance until fill_done
- fill_done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-low on sys_rst_n.
- Reset values: fill_data = 9'h000, en_write_fill = 0, busy = 0, fill_done = 0, state = IDLE, all counters 0.
- Reset asserted mid-operation: next edge returns to IDLE, no further strobes, no fill_done.
- Acceptance:
  - In IDLE, fill_flag = 1 latches x_start/x_end/y_start/y_end/color into internal registers.
  - busy rises the next cycle.
  - Later changes on the inputs have no effect on the fill in progress.
  - fill_flag while busy is ignored.
- Invalid rectangle: if latched x_end < x_start or y_end < y_start, no bytes are sent. fill_done pulses exactly 2 cycles after the accepting edge, and busy falls with it.
- Address bytes:
  - xs = x_start + X_OFFSET and xe = x_end + X_OFFSET, computed 16 bits wide. ys/ye likewise with Y_OFFSET.
  - Each address is sent high byte first, then low byte.
- Byte sequence, with fill_data values:
  - 0x02A, then xs[15:8], xs[7:0], xe[15:8], xe[7:0], each with bit8 = 1.
  - 0x12B is never used: RASET is sent as 0x02B, then ys/ye bytes with bit8 = 1.
  - 0x02C.
  - Then per pixel: {1, color[15:8]}, {1, color[7:0]}.
- States: IDLE, CHECK, SEND, WAIT, NEXT, DONE.
  - CHECK: validates the rectangle. Invalid goes to DONE.
  - SEND: drives fill_data and pulses en_write_fill for exactly 1 cycle, then goes to WAIT.
  - WAIT: holds fill_data stable until wr_done = 1, then goes to NEXT.
  - NEXT: advances the byte index, pixel byte-half and column/row counters, then goes to SEND (or to DONE after the last pixel low byte).
  - DONE: pulses fill_done for 1 cycle, drops busy, goes to IDLE.
- Timing: first en_write_fill occurs 2 cycles after the accepting edge. Gap between a wr_done and the next strobe is 2 cycles (NEXT, SEND).
- wr_done outside WAIT is ignored.
- Pixel loop:
  - 9-bit column counter runs x_start..x_end. On wrap it returns to x_start and increments the 9-bit row counter.
  - Loop ends after row y_end, column x_end, low byte.
  - Total strobes = 11 + 2·(x_end−x_start+1)·(y_end−y_start+1).
- Single-pixel rectangle (start == end on both axes) sends exactly 13 bytes.
- Full 9-bit range (0..511) must not overflow the counters.

Test Plan:
- Reset, then x 0..1, y 0..0, colour 0xF800; respond to each strobe with wr_done 3 cycles later:
  - Required stream, in order: 0x02A, 0x100, 0x102, 0x100, 0x103, 0x02B, 0x100, 0x101, 0x100, 0x101, 0x02C, 0x1F8, 0x100, 0x1F8, 0x100.
  - 15 strobes total; fill_done 1 cycle after DONE entry; busy low afterwards.
- x 5..5, y 7..7, colour 0x07E0:
  - Exactly 13 strobes; last two are 0x107, 0x1E0.
  - Column bytes 0x107/0x107; row bytes 0x108/0x108.
- x_end = 3, x_start = 4:
  - No en_write_fill ever.
  - fill_done pulses 2 cycles after acceptance.
  - busy high for exactly those cycles.
- fill_flag re-pulsed mid-fill with different coordinates:
  - Ignored; stream matches the first request byte for byte.
- sys_rst_n low for 1 cycle while in WAIT during pixel bytes:
  - Outputs return to reset values next edge; no fill_done.
  - A following fill_flag restarts from 0x02A.
- x 0..127, y 0..159 (full panel clear):
  - Count strobes = 11 + 40960 = 40971.
  - Every data strobe keeps fill_data stable until its wr_done.
  - fill_done seen exactly once.
